// File: rtl/rmt_ingress_pkt_buf.sv
// Store-and-forward AXI-Stream packet buffer feeding rmt_wrapper.
// A packet becomes visible on m_axis only after its tlast beat is stored, so
// every delivered packet is bubble-free. Packets that overflow are dropped whole.
module rmt_ingress_pkt_buf #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned DEPTH_BEATS          = 64,
    parameter int unsigned MAX_PKTS             = 16
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic [31:0]                          pkt_cnt,
    output logic [31:0]                          drop_cnt
);

    localparam int unsigned KW  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned AW  = $clog2(DEPTH_BEATS);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned QW  = $clog2(MAX_PKTS);
    localparam int unsigned QPW = QW + 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    // Beat storage and committed-packet length descriptors (no reset needed).
    logic [C_S_AXIS_DATA_WIDTH-1:0]  mem_data [DEPTH_BEATS];
    logic [KW-1:0]                   mem_keep [DEPTH_BEATS];
    logic [C_S_AXIS_TUSER_WIDTH-1:0] mem_user [DEPTH_BEATS];
    logic                            mem_last [DEPTH_BEATS];
    logic [PW-1:0]                   desc_len [MAX_PKTS];

    wr_state_t      state, state_n;
    logic [PW-1:0]  wr_ptr, wr_commit, rd_ptr, f_ptr, f_rem;
    logic [QPW-1:0] desc_wr, desc_rd, f_desc;
    logic [PW-1:0]  wr_ptr_inc;
    logic [QPW-1:0] desc_used_n;
    logic           s_acc, buf_full, m_fire, pop, load;
    logic           wr_en, commit, rollback, drop, s_ready_n;

    assign s_acc      = s_axis_tvalid & s_axis_tready;
    assign buf_full   = (wr_ptr - rd_ptr) == PW'(DEPTH_BEATS);
    assign wr_ptr_inc = wr_ptr + PW'(1);
    assign m_fire     = m_axis_tvalid & m_axis_tready;
    assign pop        = m_fire & m_axis_tlast;
    // Fetch a beat when the output stage frees up and a committed beat remains.
    assign load       = (~m_axis_tvalid | m_axis_tready) & ((f_rem != '0) | (f_desc != desc_wr));

    // Write FSM state register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= W_IDLE;
        else          state <= state_n;
    end

    // Write FSM next state and write/commit/rollback/drop strobes.
    always_comb begin
        state_n   = state;
        wr_en     = 1'b0;
        commit    = 1'b0;
        rollback  = 1'b0;
        drop      = 1'b0;
        unique case (state)
            W_IDLE: if (s_acc) begin
                if (!buf_full) begin
                    wr_en = 1'b1;
                    if (s_axis_tlast) commit  = 1'b1;
                    else              state_n = W_PKT;
                end else if (s_axis_tlast) begin
                    drop = 1'b1;
                end else begin
                    state_n = W_DROP;
                end
            end
            W_PKT: if (s_acc) begin
                if (!buf_full) begin
                    wr_en = 1'b1;
                    if (s_axis_tlast) begin
                        commit  = 1'b1;
                        state_n = W_IDLE;
                    end
                end else begin
                    rollback = 1'b1;
                    if (s_axis_tlast) begin
                        drop    = 1'b1;
                        state_n = W_IDLE;
                    end else begin
                        state_n = W_DROP;
                    end
                end
            end
            W_DROP: if (s_acc && s_axis_tlast) begin
                rollback = 1'b1;
                drop     = 1'b1;
                state_n  = W_IDLE;
            end
            default: state_n = W_IDLE;
        endcase
        desc_used_n = (desc_wr + QPW'(commit)) - (desc_rd + QPW'(pop));
        s_ready_n   = !((state_n == W_IDLE) && (desc_used_n == QPW'(MAX_PKTS)));
    end

    // Beat and descriptor storage writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr[AW-1:0]] <= s_axis_tdata;
            mem_keep[wr_ptr[AW-1:0]] <= s_axis_tkeep;
            mem_user[wr_ptr[AW-1:0]] <= s_axis_tuser;
            mem_last[wr_ptr[AW-1:0]] <= s_axis_tlast;
        end
        if (commit) desc_len[desc_wr[QW-1:0]] <= wr_ptr_inc - wr_commit;
    end

    // Pointers, descriptor queue indices, counters and ingress ready.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            wr_commit     <= '0;
            rd_ptr        <= '0;
            desc_wr       <= '0;
            desc_rd       <= '0;
            pkt_cnt       <= '0;
            drop_cnt      <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (rollback)   wr_ptr <= wr_commit;
            else if (wr_en) wr_ptr <= wr_ptr_inc;
            if (commit) begin
                wr_commit <= wr_ptr_inc;
                desc_wr   <= desc_wr + QPW'(1);
                pkt_cnt   <= pkt_cnt + 32'd1;
            end
            if (drop)   drop_cnt <= drop_cnt + 32'd1;
            if (pop)    desc_rd  <= desc_rd + QPW'(1);
            if (m_fire) rd_ptr   <= rd_ptr + PW'(1);
            s_axis_tready <= s_ready_n;
        end
    end

    // Read prefetch/output stage; walks committed packets by descriptor length.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            f_ptr         <= '0;
            f_rem         <= '0;
            f_desc        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= mem_data[f_ptr[AW-1:0]];
            m_axis_tkeep  <= mem_keep[f_ptr[AW-1:0]];
            m_axis_tuser  <= mem_user[f_ptr[AW-1:0]];
            m_axis_tlast  <= mem_last[f_ptr[AW-1:0]];
            m_axis_tvalid <= 1'b1;
            f_ptr         <= f_ptr + PW'(1);
            if (f_rem != '0) begin
                f_rem <= f_rem - PW'(1);
            end else begin
                f_rem  <= desc_len[f_desc[QW-1:0]] - PW'(1);
                f_desc <= f_desc + QPW'(1);
            end
        end else if (m_fire) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rmt_ingress_pkt_buf.sv
// Self-checking bench for rmt_ingress_pkt_buf: directed scenarios plus a
// randomized phase, all output beats compared against an expected-beat queue.
module tb_rmt_ingress_pkt_buf;

    localparam int unsigned DW    = 512;
    localparam int unsigned KW    = 64;
    localparam int unsigned UW    = 128;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned MAXP  = 16;
    localparam int unsigned BW    = DW + KW + UW + 1;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_mode   = 1;          // 0: never ready, 1: always ready, 2: random
    int sent_beats = 0;
    int out_beats  = 0;
    logic [BW-1:0] exp_q[$];
    logic          in_pkt = 1'b0;
    logic          prev_stall = 1'b0;
    logic [BW:0]   prev_obs = '0;

    rmt_ingress_pkt_buf #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .DEPTH_BEATS         (DEPTH),
        .MAX_PKTS            (MAXP)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rnd_user();
        logic [UW-1:0] r;
        for (int i = 0; i < int'(UW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Egress ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (m_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Egress monitor: beat order/content, hold-while-stalled, no bubbles in a packet.
    always @(negedge clk) begin
        logic [BW:0]   cur;
        logic [BW-1:0] exp_beat;
        if (!aresetn) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cur = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (prev_stall) check("hold_stable", 768'(cur), 768'(prev_obs));
            if (in_pkt) check("no_bubble", 768'(m_axis_tvalid), 768'(1));
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_qdepth", 768'(exp_q.size()), 768'(1));
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", 768'(cur[BW-1:0]), 768'(exp_beat));
                end
                in_pkt = !m_axis_tlast;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_obs   = cur;
        end
    end

    // Offer one beat and wait (bounded) for it to be accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic [UW-1:0] u, input logic l);
        int   budget;
        logic rdy;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        budget = 0;
        forever begin
            rdy = s_axis_tready;
            @(posedge clk);
            if (rdy) break;
            #1;
            budget++;
            if (budget > 5000) begin
                check("s_ready_timeout", 768'(0), 768'(1));
                break;
            end
        end
        #1;
        s_axis_tvalid = 1'b0;
        sent_beats++;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send a packet of random beats, optionally recording it as expected output.
    task automatic send_pkt(input int len, input int gap_max, input bit expect_out);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        for (int b = 0; b < len; b++) begin
            d = rnd_data();
            k = {$urandom, $urandom};
            u = rnd_user();
            l = (b == len - 1);
            if (expect_out) exp_q.push_back({d, k, u, l});
            send_beat(d, k, u, l);
            if (gap_max > 0) idle_cycles(int'($urandom_range(0, gap_max)));
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_left", 768'(exp_q.size()), 768'(0));
        idle_cycles(2);
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("rst_m_tvalid", 768'(m_axis_tvalid), 768'(0));
        check("rst_m_tlast", 768'(m_axis_tlast), 768'(0));
        check("rst_m_payload", 768'({m_axis_tdata, m_axis_tkeep, m_axis_tuser}), 768'(0));
        check("rst_s_tready", 768'(s_axis_tready), 768'(0));
        check("rst_counters", 768'({pkt_cnt, drop_cnt}), 768'(0));
        idle_cycles(3);
        exp_q.delete();
        sent_beats = 0;
        out_beats  = 0;
        aresetn    = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", 768'(s_axis_tready), 768'(1));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        int            lat;
        int            npk;
        int            len;
        int            budget;

        idle_cycles(2);

        // Two-beat packet with a 5-cycle upstream gap.
        m_mode = 1;
        do_reset();
        d = rnd_data(); u = rnd_user();
        exp_q.push_back({d, 64'hffffffffffffffff, u, 1'b0});
        send_beat(d, 64'hffffffffffffffff, u, 1'b0);
        idle_cycles(5);
        d = rnd_data(); u = rnd_user();
        exp_q.push_back({d, 64'h00000000000fffff, u, 1'b1});
        send_beat(d, 64'h00000000000fffff, u, 1'b1);
        lat = 0;
        while (!m_axis_tvalid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_beat_latency_le3", 768'(lat <= 3), 768'(1));
        wait_drain();
        check("t1_pkt_cnt", 768'(pkt_cnt), 768'(1));
        check("t1_drop_cnt", 768'(drop_cnt), 768'(0));

        // Ten back-to-back one-beat packets.
        do_reset();
        for (int i = 0; i < 10; i++) send_pkt(1, 0, 1'b1);
        wait_drain();
        check("t2_pkt_cnt", 768'(pkt_cnt), 768'(10));

        // Oversized packet dropped whole, following packet delivered.
        do_reset();
        send_pkt(70, 0, 1'b0);
        send_pkt(2, 0, 1'b1);
        wait_drain();
        check("t3_drop_cnt", 768'(drop_cnt), 768'(1));
        check("t3_pkt_cnt", 768'(pkt_cnt), 768'(1));

        // Descriptor queue full back-pressures the next first beat.
        m_mode = 0;
        do_reset();
        for (int i = 0; i < int'(MAXP); i++) send_pkt(1, 0, 1'b1);
        d = rnd_data(); k = {$urandom, $urandom}; u = rnd_user();
        exp_q.push_back({d, k, u, 1'b1});
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tuser = u;
        s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        idle_cycles(4);
        check("t4_s_tready_when_desc_full", 768'(s_axis_tready), 768'(0));
        check("t4_pkt_cnt_stalled", 768'(pkt_cnt), 768'(MAXP));
        m_mode = 1;
        send_beat(d, k, u, 1'b1);
        wait_drain();
        check("t4_pkt_cnt", 768'(pkt_cnt), 768'(MAXP + 1));

        // Three-beat packet with random egress stalls.
        m_mode = 2;
        do_reset();
        send_pkt(3, 0, 1'b1);
        wait_drain();
        check("t5_pkt_cnt", 768'(pkt_cnt), 768'(1));

        // Reset in the middle of a packet, then a clean packet.
        m_mode = 1;
        do_reset();
        d = rnd_data();
        send_beat(d, {$urandom, $urandom}, rnd_user(), 1'b0);
        do_reset();
        send_pkt(2, 0, 1'b1);
        wait_drain();
        check("t6_pkt_cnt", 768'(pkt_cnt), 768'(1));
        check("t6_drop_cnt", 768'(drop_cnt), 768'(0));

        // Randomized traffic, throttled so every packet fits the buffer.
        m_mode = 2;
        do_reset();
        npk = 40;
        for (int p = 0; p < npk; p++) begin
            len = (p % 13 == 12) ? int'(DEPTH) : int'($urandom_range(1, 12));
            budget = 0;
            while ((sent_beats - out_beats + len > int'(DEPTH)) && budget < 5000) begin
                @(posedge clk);
                #1;
                budget++;
            end
            if (budget >= 5000) check("throttle_timeout", 768'(0), 768'(1));
            send_pkt(len, 2, 1'b1);
        end
        wait_drain();
        check("rand_pkt_cnt", 768'(pkt_cnt), 768'(npk));
        check("rand_drop_cnt", 768'(drop_cnt), 768'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rmt_ingress_pkt_buf.md
# rmt_ingress_pkt_buf

Store-and-forward AXI-Stream packet buffer that sits directly upstream of `rmt_wrapper`, between the MAC/DMA stream and the RMT parser. It accepts 512-bit beats with arbitrary upstream bubbles. It releases a packet to `rmt_wrapper` only once that packet is completely stored, so every delivered packet is bubble-free from first beat to `tlast`. Packets that do not fit are dropped whole and counted. Truncated or partial packets never reach the pipeline.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 512, stream data width (tkeep width = /8)
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width, stored per beat
- `DEPTH_BEATS`, 64, data buffer depth in beats; must be a power of 2
- `MAX_PKTS`, 16, number of committed-packet descriptors; must be a power of 2
- `clk`  in  1  single clock for the whole block
- `aresetn`  in  1  reset, asynchronous, active-low
- `s_axis_tdata/tkeep/tuser/tvalid/tlast`  in  512/64/128/1/1  ingress stream
- `s_axis_tready`  out  1  ingress ready
- `m_axis_tdata/tkeep/tuser/tvalid/tlast`  out  512/64/128/1/1  stream to `rmt_wrapper`
- `m_axis_tready`  in  1  egress ready
- `pkt_cnt`  out  32  packets committed since reset; wraps
- `drop_cnt`  out  32  packets dropped since reset; wraps

## Operation
- Each buffer entry holds {tdata, tkeep, tuser, tlast}. tkeep and tuser pass through unmodified.
- Pointers: `wr_ptr` (speculative), `wr_commit`, `rd_ptr`, each log2(DEPTH_BEATS)+1 bits. Used = wr_ptr − rd_ptr. The buffer is full when used == DEPTH_BEATS.
- Write FSM:
  - W_IDLE (awaiting a first beat).
    - `s_axis_tready` = 1 unless the descriptor queue holds MAX_PKTS entries.
    - On an accepted beat with the buffer not full: write the beat and advance wr_ptr. If tlast, commit; otherwise go to W_PKT.
    - On an accepted beat with the buffer full: go to W_DROP, or drop immediately if tlast.
  - W_PKT.
    - `s_axis_tready` = 1.
    - On an accepted beat with the buffer not full: write it. If tlast, commit and return to W_IDLE.
    - On an accepted beat with the buffer full: set wr_ptr ← wr_commit. If the beat is tlast, count the drop and return to W_IDLE; otherwise go to W_DROP.
  - W_DROP.
    - `s_axis_tready` = 1.
    - Discard accepted beats. On tlast, set wr_ptr ← wr_commit, increment drop_cnt, and return to W_IDLE.
- Commit: wr_commit ← new wr_ptr; push the beat count (1..DEPTH_BEATS) into the descriptor queue; increment pkt_cnt.
- Read side:
  - Starts a packet only when the descriptor queue is non-empty.
  - A prefetch/output register stage presents beats. `rd_ptr` advances per consumed beat, freeing space immediately.
  - The descriptor is popped when the beat with tlast is consumed.
- Read never passes wr_commit. Uncommitted beats are never visible on m_axis.
- A commit and a descriptor pop in the same cycle leave the queue occupancy unchanged.
- A rollback (wr_ptr ← wr_commit) in the same cycle as an rd_ptr advance is legal. Free space is recomputed next cycle.

## Timing
- Reset (aresetn = 0, asynchronous):
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tkeep/tuser = 0.
  - s_axis_tready = 0 while asserted, then 1 from the first clk after deassertion.
  - Counters = 0, all pointers = 0, FSM = W_IDLE.
- Reset mid-packet discards all buffered and partial data.
- Latency: the first beat of a packet is valid on m_axis at most 3 cycles after its tlast beat is accepted, provided no earlier packet is pending.
- No bubbles within a packet: once m_axis_tvalid rises for a first beat, it stays 1 on every cycle through tlast.
- Hold rule: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis signals hold stable.
- Back-to-back packets: the first beat of the next committed packet may follow the previous tlast beat on the next cycle.
- Counters update on the cycle after the commit or drop event.

## Test plan
- Two-beat packet (tkeep 64'hffffffffffffffff then 64'h00000000000fffff) with a 5-cycle gap between beats → identical beats out contiguously; pkt_cnt=1, drop_cnt=0.
- Ten one-beat packets back-to-back with m_axis_tready=1 → ten single beats out in order, each with tlast=1; pkt_cnt=10.
- DEPTH_BEATS=64: send a 70-beat packet, then a 2-beat packet → only the 2-beat packet is output; drop_cnt=1, pkt_cnt=1; no partial beat appears on m_axis.
- m_axis_tready=0: send MAX_PKTS=16 one-beat packets, then offer a 17th → s_axis_tready=0 at the 17th first beat until m_axis_tready rises and one packet drains; all 17 are eventually output.
- Toggle m_axis_tready randomly during a 3-beat packet → data holds stable while stalled; tvalid never drops before tlast.
- Assert aresetn=0 after 1 beat of a 2-beat packet → m_axis_tvalid=0 and counters=0. The next full packet passes intact.
